// File: rtl/store_buffer_if.sv
// Request/cache-port bundle for the posted-store buffer.
// Pure wiring; no timing of its own.
// Cache ready is carried back to the buffer as the only flow-control input.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface store_buffer_if #(
  parameter int AW = `ADDR_WIDTH,
  parameter int DW = `DATA_WIDTH
);
  // Request side (EX-stage glue)
  logic          i_valid;
  logic          i_mem_action;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_data;
  logic          o_stall;
  logic          o_fwd_valid;
  logic [DW-1:0] o_fwd_data;
  // Cache side
  logic          o_cache_valid;
  logic          o_cache_action;
  logic [AW-1:0] o_cache_addr;
  logic [DW-1:0] o_cache_data;
  logic          i_cache_ready;
  // Status
  logic          o_empty;
  logic          o_full;

  // Buffer side of the bundle
  modport slave (
    input  i_valid, i_mem_action, i_addr, i_data, i_cache_ready,
    output o_stall, o_fwd_valid, o_fwd_data,
    output o_cache_valid, o_cache_action, o_cache_addr, o_cache_data,
    output o_empty, o_full
  );

  // Requester / cache-model side of the bundle
  modport master (
    output i_valid, i_mem_action, i_addr, i_data, i_cache_ready,
    input  o_stall, o_fwd_valid, o_fwd_data,
    input  o_cache_valid, o_cache_action, o_cache_addr, o_cache_data,
    input  o_empty, o_full
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-store FIFO in front of the d-cache port; loads bypass or resolve RAW.
// Latency: stores accepted in the same cycle, drain 1 entry/cycle while ready.
// Backpressure: o_stall when full (store), matched load (no fwd) or cache busy.
// Optional store-to-load forwarding: define STORE_FWD_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = `ADDR_WIDTH,
  parameter int DW    = `DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  store_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  logic [AW-1:0] mem_addr_q [DEPTH];
  logic [DW-1:0] mem_data_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          empty, full;
  logic          req_vld, is_store, is_load;
  logic          hit;
  logic [DW-1:0] hit_data;
  logic          store_acc, load_bypass, drain_done;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // Requests are masked during reset so every output reads idle.
  assign req_vld  = bus.i_valid & rst_n;
  assign is_store = req_vld & (bus.i_mem_action == WRITE);
  assign is_load  = req_vld & (bus.i_mem_action == READ);

  // Scan live slots oldest to youngest; the last hit is the one nearest tail.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] idx;
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (mem_addr_q[idx] == bus.i_addr)) begin
        hit      = 1'b1;
        hit_data = mem_data_q[idx];
      end
    end
  end

  // Full is judged on registered count, so a same-cycle drain cannot free a slot.
  assign store_acc   = is_store & ~full;
  // A load owns the cache port only when nothing pending aliases it.
  assign load_bypass = is_load & ~hit;
  assign drain_done  = ~load_bypass & ~empty & bus.i_cache_ready;

  // Cache port: bypassing load wins, otherwise the head store drains.
  always_comb begin
    bus.o_cache_valid  = 1'b0;
    bus.o_cache_action = READ;
    bus.o_cache_addr   = '0;
    bus.o_cache_data   = '0;
    if (load_bypass) begin
      bus.o_cache_valid  = 1'b1;
      bus.o_cache_action = READ;
      bus.o_cache_addr   = bus.i_addr;
    end else if (!empty) begin
      bus.o_cache_valid  = 1'b1;
      bus.o_cache_action = WRITE;
      bus.o_cache_addr   = mem_addr_q[head_q];
      bus.o_cache_data   = mem_data_q[head_q];
    end
  end

`ifdef STORE_FWD_EN
  // Aliased load is answered from the buffer and never stalls.
  always_comb begin
    bus.o_fwd_valid = is_load & hit;
    bus.o_fwd_data  = (is_load & hit) ? hit_data : '0;
    bus.o_stall     = (is_store & full) |
                      (load_bypass & ~bus.i_cache_ready);
  end
`else
  // Aliased load waits until the matching stores have drained.
  always_comb begin
    bus.o_fwd_valid = 1'b0;
    bus.o_fwd_data  = '0;
    bus.o_stall     = (is_store & full) |
                      (is_load & hit) |
                      (load_bypass & ~bus.i_cache_ready);
  end
  logic unused_hit_data;
  assign unused_hit_data = ^hit_data;
`endif

  assign bus.o_empty = empty;
  assign bus.o_full  = full;

  // Pointer and occupancy next-state; enqueue and drain together keep count.
  always_comb begin
    head_d  = drain_done ? head_q + PW'(1) : head_q;
    tail_d  = store_acc  ? tail_q + PW'(1) : tail_q;
    count_d = count_q;
    case ({store_acc, drain_done})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset discards all pending entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage written at tail on an accepted store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_addr_q[i] <= '0;
        mem_data_q[i] <= '0;
      end
    end else if (store_acc) begin
      mem_addr_q[tail_q] <= bus.i_addr;
      mem_data_q[tail_q] <= bus.i_data;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: reset, full, RAW, bypass, wrap.
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.
// Build with +define+STORE_FWD_EN to exercise the forwarding variant.
`timescale 1ns/1ps
module tb_store_buffer;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  store_buffer_if #(.AW(32), .DW(32)) bus ();

  store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic act, input logic [31:0] a, input logic [31:0] d);
    bus.i_valid      = v;
    bus.i_mem_action = act;
    bus.i_addr       = a;
    bus.i_data       = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 32'h55, 32'h0);
    bus.i_cache_ready = 1'b1;
    #2;
    n_cmp++; if (bus.o_empty !== 1'b1) begin n_bad++; $display("FAIL rst_empty got=%b exp=1", bus.o_empty); end
    n_cmp++; if (bus.o_full !== 1'b0) begin n_bad++; $display("FAIL rst_full got=%b exp=0", bus.o_full); end
    n_cmp++; if (bus.o_cache_valid !== 1'b0) begin n_bad++; $display("FAIL rst_cache_valid got=%b exp=0", bus.o_cache_valid); end
    n_cmp++; if (bus.o_stall !== 1'b0 || bus.o_fwd_valid !== 1'b0) begin n_bad++; $display("FAIL rst_stall_fwd got=%b%b exp=00", bus.o_stall, bus.o_fwd_valid); end
    n_cmp++; if (bus.o_cache_addr !== 32'h0 || bus.o_fwd_data !== 32'h0) begin n_bad++; $display("FAIL rst_data got=%h/%h exp=0", bus.o_cache_addr, bus.o_fwd_data); end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_full();
    bus.i_cache_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 32'h10 + 32'(4*i), 32'(i + 1));
      #1;
      n_cmp++; if (bus.o_stall !== 1'b0) begin n_bad++; $display("FAIL full_fill_stall[%0d] got=%b exp=0", i, bus.o_stall); end
      step();
    end
    drive(1'b1, 1'b1, 32'h20, 32'h99);
    #1;
    n_cmp++; if (bus.o_full !== 1'b1) begin n_bad++; $display("FAIL full_flag got=%b exp=1", bus.o_full); end
    n_cmp++; if (bus.o_stall !== 1'b1) begin n_bad++; $display("FAIL full_5th_stall got=%b exp=1", bus.o_stall); end
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    bus.i_cache_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (bus.o_cache_valid !== 1'b1 || bus.o_cache_action !== 1'b1 ||
          bus.o_cache_addr !== 32'h10 + 32'(4*i) || bus.o_cache_data !== 32'(i + 1)) begin
        n_bad++;
        $display("FAIL full_drain[%0d] got=v%b a%b %h/%h exp=v1 a1 %h/%h", i, bus.o_cache_valid,
                 bus.o_cache_action, bus.o_cache_addr, bus.o_cache_data, 32'h10 + 32'(4*i), 32'(i + 1));
      end
      step();
    end
    #1;
    n_cmp++; if (bus.o_empty !== 1'b1 || bus.o_cache_valid !== 1'b0) begin n_bad++; $display("FAIL full_end_empty got=e%b v%b exp=e1 v0", bus.o_empty, bus.o_cache_valid); end
  endtask

  task automatic test_raw();
    bus.i_cache_ready = 1'b0;
    drive(1'b1, 1'b1, 32'h100, 32'hA);
    step();
    drive(1'b1, 1'b1, 32'h100, 32'hB);
    step();
    drive(1'b1, 1'b0, 32'h100, 32'h0);
    #1;
`ifdef STORE_FWD_EN
    n_cmp++; if (bus.o_fwd_valid !== 1'b1 || bus.o_fwd_data !== 32'hB) begin n_bad++; $display("FAIL raw_fwd got=v%b %h exp=v1 0000000b", bus.o_fwd_valid, bus.o_fwd_data); end
    n_cmp++; if (bus.o_stall !== 1'b0) begin n_bad++; $display("FAIL raw_fwd_stall got=%b exp=0", bus.o_stall); end
    n_cmp++; if (bus.o_cache_action !== 1'b1 || bus.o_cache_data !== 32'hA) begin n_bad++; $display("FAIL raw_fwd_noread got=a%b %h exp=a1 0000000a", bus.o_cache_action, bus.o_cache_data); end
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    bus.i_cache_ready = 1'b1;
    step();
    step();
`else
    n_cmp++; if (bus.o_stall !== 1'b1 || bus.o_fwd_valid !== 1'b0) begin n_bad++; $display("FAIL raw_hold got=s%b f%b exp=s1 f0", bus.o_stall, bus.o_fwd_valid); end
    step();
    bus.i_cache_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++;
      if (bus.o_stall !== 1'b1 || bus.o_cache_action !== 1'b1 || bus.o_cache_data !== 32'(10 + i)) begin
        n_bad++;
        $display("FAIL raw_drain[%0d] got=s%b a%b %h exp=s1 a1 %h", i, bus.o_stall, bus.o_cache_action, bus.o_cache_data, 32'(10 + i));
      end
      step();
    end
    #1;
    n_cmp++; if (bus.o_stall !== 1'b0 || bus.o_cache_valid !== 1'b1 || bus.o_cache_action !== 1'b0 || bus.o_cache_addr !== 32'h100) begin
      n_bad++; $display("FAIL raw_read got=s%b v%b a%b %h exp=s0 v1 a0 00000100", bus.o_stall, bus.o_cache_valid, bus.o_cache_action, bus.o_cache_addr);
    end
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
`endif
    #1;
    n_cmp++; if (bus.o_empty !== 1'b1) begin n_bad++; $display("FAIL raw_end_empty got=%b exp=1", bus.o_empty); end
  endtask

  task automatic test_bypass();
    bus.i_cache_ready = 1'b0;
    drive(1'b1, 1'b1, 32'h300, 32'h31);
    step();
    drive(1'b1, 1'b1, 32'h304, 32'h32);
    step();
    drive(1'b1, 1'b0, 32'h200, 32'h0);
    bus.i_cache_ready = 1'b1;
    #1;
    n_cmp++; if (bus.o_cache_action !== 1'b0 || bus.o_cache_addr !== 32'h200 || bus.o_stall !== 1'b0) begin
      n_bad++; $display("FAIL byp_read got=a%b %h s%b exp=a0 00000200 s0", bus.o_cache_action, bus.o_cache_addr, bus.o_stall);
    end
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if (bus.o_cache_action !== 1'b1 || bus.o_cache_addr !== 32'h300 + 32'(4*i)) begin
        n_bad++; $display("FAIL byp_resume[%0d] got=a%b %h exp=a1 %h", i, bus.o_cache_action, bus.o_cache_addr, 32'h300 + 32'(4*i));
      end
      step();
    end
    #1;
    n_cmp++; if (bus.o_empty !== 1'b1) begin n_bad++; $display("FAIL byp_end_empty got=%b exp=1", bus.o_empty); end
  endtask

  task automatic test_wrap();
    bus.i_cache_ready = 1'b0;
    drive(1'b1, 1'b1, 32'h400, 32'h400);
    step();
    drive(1'b1, 1'b1, 32'h404, 32'h404);
    step();
    bus.i_cache_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b1, 32'h408 + 32'(4*k), 32'h408 + 32'(4*k));
      #1;
      n_cmp++;
      if (bus.o_stall !== 1'b0 || bus.o_empty !== 1'b0 || bus.o_full !== 1'b0 ||
          bus.o_cache_addr !== 32'h400 + 32'(4*k) || bus.o_cache_data !== 32'h400 + 32'(4*k)) begin
        n_bad++;
        $display("FAIL wrap[%0d] got=s%b e%b f%b %h/%h exp=s0 e0 f0 %h", k, bus.o_stall, bus.o_empty,
                 bus.o_full, bus.o_cache_addr, bus.o_cache_data, 32'h400 + 32'(4*k));
      end
      step();
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      #1;
      n_cmp++; if (bus.o_cache_addr !== 32'h418 + 32'(4*k) || bus.o_cache_valid !== 1'b1) begin
        n_bad++; $display("FAIL wrap_tail[%0d] got=v%b %h exp=v1 %h", k, bus.o_cache_valid, bus.o_cache_addr, 32'h418 + 32'(4*k));
      end
      step();
    end
    #1;
    n_cmp++; if (bus.o_empty !== 1'b1) begin n_bad++; $display("FAIL wrap_end_empty got=%b exp=1", bus.o_empty); end
  endtask

  task automatic test_reset_mid();
    bus.i_cache_ready = 1'b0;
    drive(1'b1, 1'b1, 32'h500, 32'h5);
    step();
    drive(1'b1, 1'b1, 32'h504, 32'h6);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    n_cmp++; if (bus.o_empty !== 1'b0 || bus.o_cache_valid !== 1'b1) begin n_bad++; $display("FAIL mid_prefill got=e%b v%b exp=e0 v1", bus.o_empty, bus.o_cache_valid); end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.o_empty !== 1'b1 || bus.o_cache_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset got=e%b v%b exp=e1 v0", bus.o_empty, bus.o_cache_valid); end
    step();
    rst_n = 1'b1;
    bus.i_cache_ready = 1'b1;
    step();
    #1;
    n_cmp++; if (bus.o_empty !== 1'b1 || bus.o_cache_valid !== 1'b0) begin n_bad++; $display("FAIL mid_after got=e%b v%b exp=e1 v0", bus.o_empty, bus.o_cache_valid); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    bus.i_cache_ready = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    test_reset();
    test_full();
    step();
    test_raw();
    step();
    test_bypass();
    step();
    test_wrap();
    step();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
